pipe_stage_skid: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake, a configurable skid entry, and synchronous flush. It supersedes the fixed enable/flush inter-stage latches: each stage boundary of the core (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates it with its own payload width. Back-pressure propagates without a combinational ready path, and stall cycles are counted for performance debug.

---
 rtl/pipe_pkg.sv | 55 +++++
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_stage_skid.sv | 118 +++++++++++
 tb/tb_pipe_stage_skid.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-stage types: skid FSM states and per-boundary stage bundles
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    localparam int PC_W      = 32;
    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int FLAGS_W   = 7;
    localparam int FUNCT3_W  = 3;
    localparam int FUNCT7_W  = 7;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      rs1_data;
        logic [XLEN-1:0]      rs2_data;
        logic [XLEN-1:0]      imm;
        logic [FLAGS_W-1:0]   flags;
        logic [FUNCT3_W-1:0]  funct3;
        logic [FUNCT7_W-1:0]  funct7;
    } id_ex_t;

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      alu_result;
        logic [XLEN-1:0]      store_data;
        logic [FLAGS_W-1:0]   flags;
        logic [FUNCT3_W-1:0]  funct3;
    } ex_mem_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      wb_data;
        logic [FLAGS_W-1:0]   flags;
    } mem_wb_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter shared by the performance counters
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage register with optional skid entry,
// synchronous flush and a saturating stall counter
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int SKID           = 1,
    parameter int CLEAR_ON_FLUSH = 1,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam bit CLR = (CLEAR_ON_FLUSH != 0);

    logic              in_fire;
    logic              out_fire;
    logic              stall_inc;
    logic [DATA_W-1:0] main_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign out_data = main_q;

    generate
        if (SKID != 0) begin : g_skid
            skid_state_t       state_q;
            logic [DATA_W-1:0] skid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                end else if (flush) begin
                    state_q <= EMPTY;
                    if (CLR) begin
                        main_q <= '0;
                        skid_q <= '0;
                    end
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (in_fire) begin
                                state_q <= ONE;
                                main_q  <= in_data;
                            end
                        end
                        ONE: begin
                            if (in_fire && out_fire) begin
                                main_q <= in_data;
                            end else if (in_fire) begin
                                state_q <= TWO;
                                skid_q  <= in_data;
                            end else if (out_fire) begin
                                state_q <= EMPTY;
                            end
                        end
                        TWO: begin
                            // in_ready is low here, so only the drain of main can happen
                            if (out_fire) begin
                                state_q <= ONE;
                                main_q  <= skid_q;
                            end
                        end
                        default: state_q <= EMPTY;
                    endcase
                end
            end

            assign in_ready  = (state_q != TWO);
            assign out_valid = (state_q != EMPTY);
        end else begin : g_flat
            logic valid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    main_q  <= '0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                    if (CLR) begin
                        main_q <= '0;
                    end
                end else if (in_fire) begin
                    valid_q <= 1'b1;
                    main_q  <= in_data;
                end else if (out_fire) begin
                    valid_q <= 1'b0;
                end
            end

            assign in_ready  = !valid_q || out_ready;
            assign out_valid = valid_q;
        end
    endgenerate

    assign stall_inc = out_valid && !out_ready && !flush;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (stall_inc),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard bench driving a SKID=1 and a SKID=0 stage with shared stimulus
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = 32'h0;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [31:0] out_data_a, out_data_b;
    logic [3:0]  stall_a;
    logic [15:0] stall_b;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W(32), .SKID(1), .CLEAR_ON_FLUSH(1), .CNT_W(4)
    ) u_dut_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .stall_cnt(stall_a)
    );

    pipe_stage_skid #(
        .DATA_W(32), .SKID(0), .CLEAR_ON_FLUSH(0), .CNT_W(16)
    ) u_dut_flat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .stall_cnt(stall_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 1'b0;

    // Reference model: each stage is a FIFO of capacity 2 (skid) or 1 (flat)
    logic [31:0] sb0[$];
    logic [31:0] sb1[$];
    int occ[2];
    int stall_m[2];
    bit zero_next[2];
    bit exp_in_ready[2];
    bit exp_out_valid[2];
    bit exp_zero[2];
    int exp_stall[2];

    function automatic int stall_max(input int d);
        return (d == 0) ? 15 : 65535;
    endfunction

    function automatic int sb_size(input int d);
        return (d == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic logic [31:0] sb_front(input int d);
        return (d == 0) ? sb0[0] : sb1[0];
    endfunction

    task automatic sb_push(input int d, input logic [31:0] v);
        if (d == 0) sb0.push_back(v);
        else        sb1.push_back(v);
    endtask

    task automatic sb_pop(input int d);
        if (d == 0) void'(sb0.pop_front());
        else        void'(sb1.pop_front());
    endtask

    task automatic sb_clear(input int d);
        if (d == 0) sb0.delete();
        else        sb1.delete();
    endtask

    task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got 0x%0h expected 0x%0h", d, name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and issue the model's expectations for it
    task automatic step(input logic v, input logic [31:0] dat, input logic ordy,
                        input logic fl, input logic r);
        bit acc, ofire;
        in_valid  = v;
        in_data   = dat;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        for (int d = 0; d < 2; d++) begin
            exp_zero[d]      = zero_next[d];
            exp_out_valid[d] = (occ[d] > 0);
            exp_in_ready[d]  = (d == 0) ? (occ[d] < 2) : ((occ[d] == 0) || ordy);
            exp_stall[d]     = stall_m[d];
            acc   = v && exp_in_ready[d];
            ofire = exp_out_valid[d] && ordy;
            if (acc && !fl && !r) sb_push(d, dat);
            if (r) begin
                occ[d]     = 0;
                stall_m[d] = 0;
            end else begin
                if (exp_out_valid[d] && !ordy && !fl && stall_m[d] < stall_max(d))
                    stall_m[d] = stall_m[d] + 1;
                occ[d] = fl ? 0 : occ[d] + (acc ? 1 : 0) - (ofire ? 1 : 0);
            end
            zero_next[d] = r || (fl && d == 0);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            for (int d = 0; d < 2; d++) begin
                logic        ir, ov;
                logic [31:0] od, sc;
                ir = (d == 0) ? in_ready_a  : in_ready_b;
                ov = (d == 0) ? out_valid_a : out_valid_b;
                od = (d == 0) ? out_data_a  : out_data_b;
                sc = (d == 0) ? 32'(stall_a) : 32'(stall_b);
                chk(d, "in_ready", 32'(ir), 32'(exp_in_ready[d]));
                chk(d, "out_valid", 32'(ov), 32'(exp_out_valid[d]));
                chk(d, "stall_cnt", sc, 32'(exp_stall[d]));
                if (exp_zero[d]) chk(d, "out_data_cleared", od, 32'h0);
                if (ov) begin
                    if (sb_size(d) == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL dut%0d unexpected_output: got 0x%0h expected none", d, od);
                    end else begin
                        chk(d, "out_data", od, sb_front(d));
                        if (out_ready) sb_pop(d);
                    end
                end
                if (flush || rst) sb_clear(d);
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            occ[d]       = 0;
            stall_m[d]   = 0;
            zero_next[d] = 1'b1;
        end
        @(posedge clk);
        #1;
        checking = 1'b1;

        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // streaming
        step(1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // back-pressure absorbed by the skid entry
        step(1'b1, 32'hA, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // flush while holding two entries
        step(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h77, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h88, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // full-rate stream with a one-cycle out_ready gap
        for (int i = 0; i < 8; i++) step(1'b1, 32'h100 + 32'(i), (i != 3), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // stall counter saturation
        step(1'b1, 32'h99, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // reset mid-stream
        step(1'b1, 32'h21, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // multi-cycle flush drops every input
        step(1'b1, 32'h31, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h40 + 32'(i), 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0,
                 ($urandom % 25) == 0, ($urandom % 80) == 0);
        end

        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checking = 1'b0;
        for (int d = 0; d < 2; d++) chk(d, "scoreboard_drained", 32'(sb_size(d)), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
